// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
//   Byte-level command decoder placed directly after the UART receiver.
//   Frames:  'W'(0x57) ADDR DATA  -> one register-bus write
//            'R'(0x52) ADDR       -> one register-bus read, read byte is
//                                    returned to the UART transmitter
//   Optional feature macro: UART_CMD_CHKSUM_EN
//     When defined, every frame carries a trailing checksum byte equal to the
//     XOR of all preceding frame bytes. A mismatch raises err and drops the
//     frame. When undefined, frames execute straight after ADDR / DATA.
//
// Ports
//   clk        in   1       system clock
//   rstb       in   1       asynchronous active-low reset
//   clk_en     in   1       16x oversample strobe, advances the inter-byte timeout
//   rx_valid   in   1       1-cycle pulse, rx_data holds a new byte
//   rx_data    in   8       received byte
//   reg_wr     out  1       1-cycle write strobe
//   reg_rd     out  1       1-cycle read strobe
//   reg_addr   out  ADDR_W  register address, stable from strobe until next strobe
//   reg_wdata  out  8       write data, valid with reg_wr
//   reg_rdata  in   8       read data, valid exactly 1 cycle after reg_rd
//   tx_start   out  1       1-cycle pulse, transmitter loads tx_data
//   tx_data    out  8       reply byte, held until the next reply
//   tx_busy    in   1       transmitter busy, tx_start is held off while 1
//   err        out  1       1-cycle pulse per framing / protocol error
// ---------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter int ADDR_W   = 8,
    parameter int TO_TICKS = 2048,
    parameter int TO_W     = 12
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              clk_en,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              reg_wr,
    output logic              reg_rd,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              err
);

    localparam logic [7:0]      CMD_W   = 8'h57;
    localparam logic [7:0]      CMD_R   = 8'h52;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
`ifdef UART_CMD_CHKSUM_EN
        S_CHK,
`endif
        S_WR,
        S_RD,
        S_RDCAP,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              cmd_rd_q, cmd_rd_d;   // 1 = read frame, 0 = write frame
    logic [ADDR_W-1:0] acap_q, acap_d;       // address of the frame being received
    logic [ADDR_W-1:0] raddr_q, raddr_d;     // address presented on the bus
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        txd_q, txd_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              err_q, err_d;
    logic              counting;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]        chk_q, chk_d;         // running XOR of the frame bytes
`endif

    assign reg_addr  = raddr_q;
    assign reg_wdata = wdata_q;
    assign tx_data   = txd_q;
    assign err       = err_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= S_IDLE;
            cmd_rd_q <= 1'b0;
            acap_q   <= '0;
            raddr_q  <= '0;
            wdata_q  <= '0;
            txd_q    <= '0;
            to_q     <= '0;
            err_q    <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
            chk_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cmd_rd_q <= cmd_rd_d;
            acap_q   <= acap_d;
            raddr_q  <= raddr_d;
            wdata_q  <= wdata_d;
            txd_q    <= txd_d;
            to_q     <= to_d;
            err_q    <= err_d;
`ifdef UART_CMD_CHKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_rd_d = cmd_rd_q;
        acap_d   = acap_q;
        raddr_d  = raddr_q;
        wdata_d  = wdata_q;
        txd_d    = txd_q;
        to_d     = '0;          // cleared on every accepted byte and outside a frame
        err_d    = 1'b0;
        reg_wr   = 1'b0;
        reg_rd   = 1'b0;
        tx_start = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
        chk_d    = chk_q;
`endif

        counting = (state_q == S_ADDR) || (state_q == S_DATA);
`ifdef UART_CMD_CHKSUM_EN
        counting = counting || (state_q == S_CHK);
`endif

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_W || rx_data == CMD_R) begin
                        cmd_rd_d = (rx_data == CMD_R);
                        state_d  = S_ADDR;
`ifdef UART_CMD_CHKSUM_EN
                        chk_d    = rx_data;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_ADDR: begin
                if (rx_valid) begin
                    acap_d = rx_data[ADDR_W-1:0];
`ifdef UART_CMD_CHKSUM_EN
                    chk_d   = chk_q ^ rx_data;
                    state_d = cmd_rd_q ? S_CHK : S_DATA;
`else
                    if (cmd_rd_q) begin
                        raddr_d = rx_data[ADDR_W-1:0];
                        state_d = S_RD;
                    end else begin
                        state_d = S_DATA;
                    end
`endif
                end
            end

            S_DATA: begin
                if (rx_valid) begin
                    wdata_d = rx_data;
`ifdef UART_CMD_CHKSUM_EN
                    chk_d   = chk_q ^ rx_data;
                    state_d = S_CHK;
`else
                    raddr_d = acap_q;
                    state_d = S_WR;
`endif
                end
            end

`ifdef UART_CMD_CHKSUM_EN
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        raddr_d = acap_q;
                        state_d = cmd_rd_q ? S_RD : S_WR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif

            // Bytes arriving while a frame executes are dropped and flagged.
            S_WR: begin
                reg_wr  = 1'b1;
                err_d   = rx_valid;
                state_d = S_IDLE;
            end

            S_RD: begin
                reg_rd  = 1'b1;
                err_d   = rx_valid;
                state_d = S_RDCAP;
            end

            S_RDCAP: begin
                txd_d   = reg_rdata;
                err_d   = rx_valid;
                state_d = S_RESP;
            end

            S_RESP: begin
                err_d = rx_valid;
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Inter-byte timeout; an accepted byte in the same cycle wins.
        if (counting && !rx_valid) begin
            to_d = to_q;
            if (clk_en) begin
                if (to_q == TO_LAST) begin
                    to_d    = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_parser
//   Scoreboard bench: the stimulus side feeds every byte / idle cycle into a
//   frame-level reference model that queues expected writes, reads, replies
//   and error pulses; an independent monitor pops and compares whenever the
//   DUT strobes an output. A small responder plays the register file.
// ---------------------------------------------------------------------------
module tb_uart_cmd_parser;

    localparam int ADDR_W   = 8;
    localparam int TO_TICKS = 64;
    localparam int TO_W     = 7;
`ifdef UART_CMD_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [7:0] CW = 8'h57;
    localparam logic [7:0] CR = 8'h52;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              clk_en = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              reg_wr, reg_rd;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic [7:0]        reg_rdata = 8'h00;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic              err;

    uart_cmd_parser #(.ADDR_W(ADDR_W), .TO_TICKS(TO_TICKS), .TO_W(TO_W)) dut (
        .clk(clk), .rstb(rstb), .clk_en(clk_en), .rx_valid(rx_valid), .rx_data(rx_data),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .err(err)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic [7:0] d; int cyc; } tx_t;

    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    tx_t        tx_q[$];
    int         exp_err    = 0;
    int         vectors    = 0;
    int         fails      = 0;
    int         cyc        = 0;
    int         busy_until = 0;
    logic [7:0] regfile[256];

    // reference model state: bytes of the frame collected so far
    logic [7:0] mbuf[4];
    int         mbuf_n = 0;
    int         mticks = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // register file: answers exactly one cycle after reg_rd, garbage otherwise
    initial begin : responder
        logic       seen;
        logic [7:0] a;
        forever begin
            @(negedge clk);
            seen = reg_rd;
            a    = reg_addr;
            @(posedge clk);
            #1;
            reg_rdata = seen ? regfile[a] : 8'($urandom);
        end
    end

    function automatic int frame_len(input logic [7:0] c);
        return ((c == CW) ? 3 : 2) + (CHK ? 1 : 0);
    endfunction

    task automatic model_byte(input logic [7:0] d);
        logic [7:0] x;
        int         t;
        mticks = 0;
        if (mbuf_n == 0) begin
            if (d == CW || d == CR) begin
                mbuf[0] = d;
                mbuf_n  = 1;
            end else begin
                exp_err++;
            end
        end else begin
            mbuf[mbuf_n] = d;
            mbuf_n++;
            if (mbuf_n == frame_len(mbuf[0])) begin
                x = 8'h00;
                for (int i = 0; i < mbuf_n - 1; i++) x = x ^ mbuf[i];
                if (CHK && x != mbuf[mbuf_n-1]) begin
                    exp_err++;
                end else if (mbuf[0] == CW) begin
                    wr_q.push_back('{mbuf[1], mbuf[2]});
                end else begin
                    // reply no earlier than 3 clocks after the last byte, and
                    // in the first cycle the transmitter is free
                    t = (busy_until > cyc + 3) ? busy_until : cyc + 3;
                    rd_q.push_back(mbuf[1]);
                    tx_q.push_back('{regfile[mbuf[1]], t});
                end
                mbuf_n = 0;
            end
        end
    endtask

    // one clock of stimulus; bk >= 0 starts a busy window of bk cycles
    task automatic cycle(input bit v, input logic [7:0] d, input bit ce, input int bk, input bit drop);
        @(posedge clk);
        #1;
        if (bk >= 0) busy_until = cyc + bk;
        rx_valid = v;
        rx_data  = v ? d : 8'($urandom);
        clk_en   = ce;
        tx_busy  = (cyc < busy_until);
        if (v) begin
            if (drop) exp_err++;
            else      model_byte(d);
        end else if (mbuf_n > 0 && ce) begin
            mticks++;
            if (mticks >= TO_TICKS) begin
                exp_err++;
                mbuf_n = 0;
                mticks = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), -1, 1'b0);
    endtask

    task automatic silence(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, -1, 1'b0);
    endtask

    task automatic mk_frame(input bit rd, input logic [7:0] a, input logic [7:0] d,
                            output logic [7:0] b[4], output int n);
        logic [7:0] x;
        b[0] = rd ? CR : CW;
        b[1] = a;
        b[2] = d;
        b[3] = 8'h00;
        n    = rd ? 2 : 3;
        if (CHK) begin
            x = 8'h00;
            for (int i = 0; i < n; i++) x = x ^ b[i];
            b[n] = x;
            n++;
        end
    endtask

    // sends bytes 0..upto-1; long_at selects a byte preceded by TO_TICKS-1 ticks
    task automatic send_bytes(input logic [7:0] b[4], input int upto, input int bk, input int long_at);
        for (int i = 0; i < upto; i++) begin
            if (i > 0) begin
                if (i == long_at) silence(TO_TICKS - 1);
                else              idle($urandom_range(0, 12));
            end
            cycle(1'b1, b[i], (i == long_at) ? 1'b1 : 1'($urandom_range(0, 1)),
                  (i == upto - 1) ? bk : -1, 1'b0);
        end
    endtask

    task automatic check_zero(input string name, input logic [31:0] v);
        vectors++;
        if (v !== 32'h0) begin
            fails++;
            $display("FAIL %s: got %h, required 0", name, v);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rstb       = 1'b0;
        mbuf_n     = 0;
        mticks     = 0;
        busy_until = 0;
        tx_busy    = 1'b0;
        #1;
        check_zero("rst_reg_wr", {31'h0, reg_wr});
        check_zero("rst_reg_rd", {31'h0, reg_rd});
        check_zero("rst_tx_start", {31'h0, tx_start});
        check_zero("rst_err", {31'h0, err});
        check_zero("rst_reg_addr", {24'h0, reg_addr});
        check_zero("rst_reg_wdata", {24'h0, reg_wdata});
        check_zero("rst_tx_data", {24'h0, tx_data});
        repeat (2) @(posedge clk);
        #2;
        rstb = 1'b1;
    endtask

    // monitor: pops the scoreboard whenever the DUT presents an output
    initial begin : monitor
        wr_t        we;
        tx_t        te;
        logic [7:0] ra;
        forever begin
            @(negedge clk);
            if (rstb === 1'b1) begin
                if (reg_wr) begin
                    vectors++;
                    if (wr_q.size() == 0) begin
                        fails++;
                        $display("FAIL wr_unexpected: got write addr=%h data=%h cyc=%0d, required none",
                                 reg_addr, reg_wdata, cyc);
                    end else begin
                        we = wr_q.pop_front();
                        if (reg_addr !== we.a || reg_wdata !== we.d || reg_rd !== 1'b0) begin
                            fails++;
                            $display("FAIL wr_data: got addr=%h data=%h rd=%b, required addr=%h data=%h rd=0",
                                     reg_addr, reg_wdata, reg_rd, we.a, we.d);
                        end
                    end
                end
                if (reg_rd) begin
                    vectors++;
                    if (rd_q.size() == 0) begin
                        fails++;
                        $display("FAIL rd_unexpected: got read addr=%h cyc=%0d, required none", reg_addr, cyc);
                    end else begin
                        ra = rd_q.pop_front();
                        if (reg_addr !== ra || reg_wr !== 1'b0) begin
                            fails++;
                            $display("FAIL rd_addr: got addr=%h wr=%b, required addr=%h wr=0", reg_addr, reg_wr, ra);
                        end
                    end
                end
                if (tx_start) begin
                    vectors++;
                    if (tx_q.size() == 0) begin
                        fails++;
                        $display("FAIL tx_unexpected: got tx_start data=%h cyc=%0d, required none", tx_data, cyc);
                    end else begin
                        te = tx_q.pop_front();
                        if (tx_data !== te.d || cyc != te.cyc || tx_busy !== 1'b0) begin
                            fails++;
                            $display("FAIL tx_reply: got data=%h cyc=%0d busy=%b, required data=%h cyc=%0d busy=0",
                                     tx_data, cyc, tx_busy, te.d, te.cyc);
                        end
                    end
                end
                if (err) begin
                    vectors++;
                    if (exp_err == 0) begin
                        fails++;
                        $display("FAIL err_unexpected: got err=1 cyc=%0d, required no error", cyc);
                    end else begin
                        exp_err--;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] b[4];
        int         n;
        int         kind;
        int         bk;

        for (int i = 0; i < 256; i++) regfile[i] = 8'($urandom);
        regfile[8'h34] = 8'hC3;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero("init_reg_wr", {31'h0, reg_wr});
        check_zero("init_reg_rd", {31'h0, reg_rd});
        check_zero("init_tx_start", {31'h0, tx_start});
        check_zero("init_err", {31'h0, err});
        check_zero("init_reg_addr", {24'h0, reg_addr});
        check_zero("init_tx_data", {24'h0, tx_data});
        rstb = 1'b1;
        idle(3);

        // write 57 12 A5
        mk_frame(1'b0, 8'h12, 8'hA5, b, n);
        send_bytes(b, n, 0, -1);
        idle(6);

        // read 52 34 -> C3, transmitter free
        mk_frame(1'b1, 8'h34, 8'h00, b, n);
        send_bytes(b, n, 0, -1);
        idle(6);

        // read with transmitter busy for 100 clocks
        send_bytes(b, n, 100, -1);
        idle(106);

        // bad command, then a normal write of FF to 01
        cycle(1'b1, 8'h41, 1'b0, -1, 1'b0);
        idle(4);
        mk_frame(1'b0, 8'h01, 8'hFF, b, n);
        send_bytes(b, n, 0, -1);
        idle(6);

        // timeout after 57 12, then a working frame
        mk_frame(1'b0, 8'h12, 8'h5A, b, n);
        send_bytes(b, 2, -1, -1);
        silence(TO_TICKS + 3);
        idle(4);
        send_bytes(b, n, 0, -1);
        idle(6);

        // byte arriving one tick short of the timeout, on a clk_en cycle
        mk_frame(1'b0, 8'h77, 8'h3C, b, n);
        send_bytes(b, n, 0, 1);
        idle(6);

`ifdef UART_CMD_CHKSUM_EN
        b[0] = 8'h57; b[1] = 8'h12; b[2] = 8'hA5; b[3] = 8'hE0;
        send_bytes(b, 4, 0, -1);
        idle(6);
        b[3] = 8'h00;
        send_bytes(b, 4, 0, -1);
        idle(6);
`endif

        // byte dropped while the reply waits for the transmitter
        mk_frame(1'b1, 8'h9E, 8'h00, b, n);
        send_bytes(b, n, 30, -1);
        idle(10);
        cycle(1'b1, 8'h57, 1'b1, -1, 1'b1);
        idle(26);

        // reset mid-frame after 57, then read 52 34
        cycle(1'b1, 8'h57, 1'b0, -1, 1'b0);
        idle(2);
        apply_reset();
        idle(2);
        mk_frame(1'b1, 8'h34, 8'h00, b, n);
        send_bytes(b, n, 0, -1);
        idle(6);

        // reset while the reply is pending: no tx_start may follow
        mk_frame(1'b1, 8'h55, 8'h00, b, n);
        send_bytes(b, n, 60, -1);
        idle(10);
        apply_reset();
        void'(tx_q.pop_back());
        idle(70);

        // randomized frames
        for (int k = 0; k < 150; k++) begin
            kind = $urandom_range(0, 5);
            bk   = 0;
            case (kind)
                0, 5: begin
                    mk_frame(1'b0, 8'($urandom), 8'($urandom), b, n);
                    if (kind == 5 && CHK) b[n-1] = b[n-1] ^ 8'($urandom_range(1, 255));
                    send_bytes(b, n, 0, -1);
                end
                1: begin
                    bk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
                    mk_frame(1'b1, 8'($urandom), 8'h00, b, n);
                    send_bytes(b, n, bk, -1);
                end
                2: begin
                    n = $urandom_range(0, 255);
                    if (n == 32'h57 || n == 32'h52) n = 32'h00;
                    cycle(1'b1, 8'(n), 1'($urandom_range(0, 1)), -1, 1'b0);
                end
                3: begin
                    mk_frame($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), b, n);
                    send_bytes(b, $urandom_range(1, n - 1), -1, -1);
                    silence(TO_TICKS + $urandom_range(0, 5));
                end
                default: begin
                    mk_frame($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), b, n);
                    send_bytes(b, n, 0, $urandom_range(1, n - 1));
                end
            endcase
            idle(bk + 6);
        end

        idle(20);
        check_zero("left_writes", wr_q.size());
        check_zero("left_reads", rd_q.size());
        check_zero("left_replies", tx_q.size());
        check_zero("left_errors", exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
